pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central hazard and sequencing controller for the five-stage RV32i pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and generates the EX-stage operand forwarding selects. It freezes the whole pipeline while the data memory handshake is outstanding, with a timeout into a fault state. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MEM_TIMEOUT, 16, max freeze cycles per memory access before fault (≥2)
- CNT_WIDTH, 32, width of Stall_Count

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-low reset (RST == 0 resets on posedge CLK)
- RS1_D, RS2_D  in  5  source registers in Decode
- RS1_E, RS2_E, RD_E  in  5  source/destination registers in Execute
- Result_Src_Sel_E  in  2  result select of instruction in Execute (RESULT_SRC_MEM = load)
- PC_Src_Sel_E  in  1  branch taken / jump redirect from Execute
- RD_M, RD_W  in  5  destination registers in Memory/Writeback
- REG_W_En_M, REG_W_En_W  in  1  write enables in Memory/Writeback
- MEM_Req_M  in  1  load/store present in Memory stage
- MEM_Ready  in  1  data memory completes access this cycle
- Stall_F, Stall_D, Stall_E, Stall_M  out  1  hold PC / IF/ID / ID/EX / EX/MEM
- Flush_D, Flush_E, Flush_W  out  1  insert NOP into IF/ID / ID/EX / MEM/WB
- Forward_A_Sel_E, Forward_B_Sel_E  out  2  operand forwarding selects
- MEM_Fault  out  1  memory timeout, sticky until reset
- Stall_Count  out  CNT_WIDTH  cycles with Stall_F asserted, saturating

## Operation
- FSM states: CTRL_RUN, CTRL_MEM_WAIT, CTRL_FAULT.
- Freeze = (RUN & MEM_Req_M & !MEM_Ready) | (MEM_WAIT & !MEM_Ready) | FAULT.
- Freeze asserts Stall_F/D/E/M = 1 and Flush_W = 1. It suppresses all flushes other than Flush_W, and suppresses the load-use stall logic.
- Branch, when not frozen: PC_Src_Sel_E = 1 gives Flush_D = Flush_E = 1 and Stall_F = Stall_D = 0. Branch beats load-use.
- Load-use, when not frozen and no branch: Result_Src_Sel_E == RESULT_SRC_MEM, RD_E ≠ 0 and RD_E ∈ {RS1_D, RS2_D} gives Stall_F = Stall_D = Flush_E = 1.
- Forwarding for operand A, from RS1_E:
  - FWD_M if REG_W_En_M, RD_M ≠ 0 and RD_M == RS1_E;
  - else FWD_W if the same conditions hold on W;
  - else FWD_NONE.
  - M beats W. Operand B is identical using RS2_E.
- Forwarding selects are independent of freeze and stalls.
- Transitions:
  - RUN → MEM_WAIT when MEM_Req_M & !MEM_Ready; Wait_Count ← 1.
  - MEM_WAIT → RUN when MEM_Ready; Wait_Count ← 0.
  - MEM_WAIT → FAULT when !MEM_Ready and Wait_Count == MEM_TIMEOUT−1; otherwise Wait_Count++.
  - FAULT holds until reset. MEM_Fault = (state == FAULT).
- Stall_Count increments on each posedge where Stall_F == 1. It holds at all-ones once saturated.

## Timing
- All stall, flush and forward outputs are combinational from the current inputs and state, valid in the same cycle. The FSM and counters update on posedge CLK.
- Reset (RST == 0 at posedge) sets state = RUN, Wait_Count = 0, Stall_Count = 0, MEM_Fault = 0.
- While RST == 0, outputs are:
  - Stall_* = 0
  - Flush_D = Flush_E = Flush_W = 1
  - Forward_*_Sel_E = FWD_NONE
- Reset mid-wait or in FAULT returns to RUN on the next edge and ignores MEM_Ready in that cycle.
- MEM_Ready = 1 in the same cycle as MEM_Req_M gives zero freeze cycles and no state change.
- The pipeline is frozen for exactly MEM_TIMEOUT cycles before FAULT. FAULT is entered on the edge ending the MEM_TIMEOUT-th freeze cycle.
- A branch pending in E during a freeze takes effect in the first unfrozen cycle, because E is held.

## Structure
- definitions package:
  - ctrl_state_t enum (CTRL_RUN, CTRL_MEM_WAIT, CTRL_FAULT)
  - forward_sel_t: FWD_NONE = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10
  - RESULT_SRC_MEM = 2'b01
- Sub-module forwarding_unit: purely combinational, instantiated twice (A and B).
- FSM, counters and priority logic live in the top module.

## Test plan
- Reset: RST = 0 for 2 cycles → Flush_D/E/W = 1, Stall_Count = 0, MEM_Fault = 0; then RST = 1 → all stalls and flushes 0.
- Load-use: RD_E = 5, Result_Src_Sel_E = 01, RS2_D = 5 → Stall_F = Stall_D = Flush_E = 1 that cycle; Stall_Count = 1 after the edge. Repeat with RD_E = 0 → no stall.
- Branch plus load-use together: PC_Src_Sel_E = 1 with the above hazard → Flush_D = Flush_E = 1, Stall_F = 0.
- Forward priority: RS1_E = 7, RD_M = RD_W = 7, both write enables 1 → Forward_A = FWD_M. With REG_W_En_M = 0 → FWD_W. With RD = 0 → FWD_NONE.
- Memory wait: MEM_Req_M = 1, MEM_Ready low 3 cycles then high → Stall_F/D/E/M and Flush_W high exactly 3 cycles, state back to RUN, Stall_Count += 3.
- Timeout: MEM_TIMEOUT = 16, MEM_Ready held 0 → MEM_Fault = 1 after 16 frozen cycles, freeze stays asserted; RST = 0 for one edge → RUN, MEM_Fault = 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the interface, the forwarding unit and the top.
package pipeline_hazard_controller_pkg;

   typedef enum logic [1:0] {
      CTRL_RUN      = 2'b00,
      CTRL_MEM_WAIT = 2'b01,
      CTRL_FAULT    = 2'b10
   } ctrl_state_t;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_W    = 2'b01,
      FWD_M    = 2'b10
   } forward_sel_t;

   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
   localparam logic [4:0] REG_ZERO       = 5'd0;

   // x0 is hardwired, so it never produces a dependency
   function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != REG_ZERO) && (rd == rs);
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller.
// The slave modport is the controller; the master modport is the pipeline.
interface pipeline_hazard_controller_if
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int CNT_WIDTH = 32
);
   logic [4:0]           RS1_D;
   logic [4:0]           RS2_D;
   logic [4:0]           RS1_E;
   logic [4:0]           RS2_E;
   logic [4:0]           RD_E;
   logic [1:0]           Result_Src_Sel_E;
   logic                 PC_Src_Sel_E;
   logic [4:0]           RD_M;
   logic [4:0]           RD_W;
   logic                 REG_W_En_M;
   logic                 REG_W_En_W;
   logic                 MEM_Req_M;
   logic                 MEM_Ready;
   logic                 Stall_F;
   logic                 Stall_D;
   logic                 Stall_E;
   logic                 Stall_M;
   logic                 Flush_D;
   logic                 Flush_E;
   logic                 Flush_W;
   forward_sel_t         Forward_A_Sel_E;
   forward_sel_t         Forward_B_Sel_E;
   logic                 MEM_Fault;
   logic [CNT_WIDTH-1:0] Stall_Count;

   modport master (
      output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, Result_Src_Sel_E, PC_Src_Sel_E,
             RD_M, RD_W, REG_W_En_M, REG_W_En_W, MEM_Req_M, MEM_Ready,
      input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
             Forward_A_Sel_E, Forward_B_Sel_E, MEM_Fault, Stall_Count
   );

   modport slave (
      input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, Result_Src_Sel_E, PC_Src_Sel_E,
             RD_M, RD_W, REG_W_En_M, REG_W_En_W, MEM_Req_M, MEM_Ready,
      output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
             Forward_A_Sel_E, Forward_B_Sel_E, MEM_Fault, Stall_Count
   );

endinterface

// File: rtl/pipeline_hazard_controller_forwarding_unit.sv
// EX-stage operand bypass select for one source register.
// Memory-stage result is younger than writeback, so it wins.
module forwarding_unit
   import pipeline_hazard_controller_pkg::*;
(
   input  logic [4:0]   rs_e,
   input  logic [4:0]   rd_m,
   input  logic         reg_w_en_m,
   input  logic [4:0]   rd_w,
   input  logic         reg_w_en_w,
   output forward_sel_t fwd_sel
);

   always_comb begin
      fwd_sel = FWD_NONE;
      if (reg_w_en_m && reg_match(rd_m, rs_e)) begin
         fwd_sel = FWD_M;
      end else if (reg_w_en_w && reg_match(rd_w, rs_e)) begin
         fwd_sel = FWD_W;
      end
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencing, memory-freeze FSM with timeout, and stall-cycle counter.
//
// state          | meaning
// CTRL_RUN       | normal issue; branch and load-use hazards resolved here
// CTRL_MEM_WAIT  | data access outstanding, whole pipeline frozen
// CTRL_FAULT     | memory timed out; frozen until reset
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 32
)
(
   input  logic                          CLK,
   input  logic                          RST,
   pipeline_hazard_controller_if.slave   hz
);

   localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   // The RUN-cycle miss is the first frozen cycle, so the wait state covers the rest
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 2);

   ctrl_state_t           state;
   ctrl_state_t           state_nxt;
   logic [WAIT_W-1:0]     wait_left;
   logic [WAIT_W-1:0]     wait_nxt;
   logic [CNT_WIDTH-1:0]  stall_cnt;
   logic                  freeze;
   logic                  load_use;
   forward_sel_t          fwd_a;
   forward_sel_t          fwd_b;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= CTRL_RUN;
         wait_left <= '0;
      end else begin
         state     <= state_nxt;
         wait_left <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_left;
      unique case (state)
         CTRL_RUN: begin
            if (hz.MEM_Req_M && !hz.MEM_Ready) begin
               state_nxt = CTRL_MEM_WAIT;
               wait_nxt  = WAIT_LOAD;
            end
         end
         CTRL_MEM_WAIT: begin
            if (hz.MEM_Ready) begin
               state_nxt = CTRL_RUN;
               wait_nxt  = '0;
            end else if (wait_left == '0) begin
               state_nxt = CTRL_FAULT;
            end else begin
               wait_nxt = wait_left - 1'b1;
            end
         end
         CTRL_FAULT: begin
            state_nxt = CTRL_FAULT;
         end
         default: begin
            state_nxt = CTRL_RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   assign freeze = ((state == CTRL_RUN) && hz.MEM_Req_M && !hz.MEM_Ready)
                 || ((state == CTRL_MEM_WAIT) && !hz.MEM_Ready)
                 || (state == CTRL_FAULT);

   assign load_use = (hz.Result_Src_Sel_E == RESULT_SRC_MEM)
                   && (reg_match(hz.RD_E, hz.RS1_D) || reg_match(hz.RD_E, hz.RS2_D));

   forwarding_unit u_fwd_a (
      .rs_e       (hz.RS1_E),
      .rd_m       (hz.RD_M),
      .reg_w_en_m (hz.REG_W_En_M),
      .rd_w       (hz.RD_W),
      .reg_w_en_w (hz.REG_W_En_W),
      .fwd_sel    (fwd_a)
   );

   forwarding_unit u_fwd_b (
      .rs_e       (hz.RS2_E),
      .rd_m       (hz.RD_M),
      .reg_w_en_m (hz.REG_W_En_M),
      .rd_w       (hz.RD_W),
      .reg_w_en_w (hz.REG_W_En_W),
      .fwd_sel    (fwd_b)
   );

   // Priority: reset > freeze > branch > load-use
   always_comb begin
      hz.Stall_F         = 1'b0;
      hz.Stall_D         = 1'b0;
      hz.Stall_E         = 1'b0;
      hz.Stall_M         = 1'b0;
      hz.Flush_D         = 1'b0;
      hz.Flush_E         = 1'b0;
      hz.Flush_W         = 1'b0;
      hz.Forward_A_Sel_E = FWD_NONE;
      hz.Forward_B_Sel_E = FWD_NONE;
      if (!RST) begin
         hz.Flush_D = 1'b1;
         hz.Flush_E = 1'b1;
         hz.Flush_W = 1'b1;
      end else begin
         hz.Forward_A_Sel_E = fwd_a;
         hz.Forward_B_Sel_E = fwd_b;
         if (freeze) begin
            hz.Stall_F = 1'b1;
            hz.Stall_D = 1'b1;
            hz.Stall_E = 1'b1;
            hz.Stall_M = 1'b1;
            hz.Flush_W = 1'b1;
         end else if (hz.PC_Src_Sel_E) begin
            hz.Flush_D = 1'b1;
            hz.Flush_E = 1'b1;
         end else if (load_use) begin
            hz.Stall_F = 1'b1;
            hz.Stall_D = 1'b1;
            hz.Flush_E = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         stall_cnt <= '0;
      end else if (hz.Stall_F && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign hz.Stall_Count = stall_cnt;
   assign hz.MEM_Fault   = (state == CTRL_FAULT);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and random stimulus for the hazard controller, checked against a
// cycle-level behavioural model of freeze length, fault and stall counting.
module tb_pipeline_hazard_controller;
   import pipeline_hazard_controller_pkg::*;

   localparam int TIMEOUT = 16;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   int          m_freeze_len;
   bit          m_fault;
   logic [31:0] m_count;
   bit          last_frz;

   pipeline_hazard_controller_if #(.CNT_WIDTH(32)) hif ();

   pipeline_hazard_controller #(
      .MEM_TIMEOUT (TIMEOUT),
      .CNT_WIDTH   (32)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .hz  (hif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic [4:0] rd_m,
                                          input logic we_m, input logic [4:0] rd_w,
                                          input logic we_w);
      if (we_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
      if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic set_idle();
      hif.RS1_D = 5'd0; hif.RS2_D = 5'd0; hif.RS1_E = 5'd0; hif.RS2_E = 5'd0;
      hif.RD_E = 5'd0; hif.Result_Src_Sel_E = 2'b00; hif.PC_Src_Sel_E = 1'b0;
      hif.RD_M = 5'd0; hif.RD_W = 5'd0; hif.REG_W_En_M = 1'b0; hif.REG_W_En_W = 1'b0;
      hif.MEM_Req_M = 1'b0; hif.MEM_Ready = 1'b0;
   endtask

   // Called just after a falling edge with inputs applied; returns at the next falling edge.
   task automatic run_cycle();
      logic frz, lu;
      logic sf, sd, se, sm, fd, fe, fw;
      logic [1:0] fa, fb;
      #1;
      frz = m_fault || ((hif.MEM_Req_M || m_freeze_len > 0) && !hif.MEM_Ready);
      lu  = (hif.Result_Src_Sel_E == 2'b01) && (hif.RD_E != 5'd0)
            && (hif.RD_E == hif.RS1_D || hif.RD_E == hif.RS2_D);
      {sf, sd, se, sm, fd, fe, fw} = '0;
      fa = fwd_ref(hif.RS1_E, hif.RD_M, hif.REG_W_En_M, hif.RD_W, hif.REG_W_En_W);
      fb = fwd_ref(hif.RS2_E, hif.RD_M, hif.REG_W_En_M, hif.RD_W, hif.REG_W_En_W);
      if (!rst) begin
         fd = 1'b1; fe = 1'b1; fw = 1'b1;
         fa = 2'b00; fb = 2'b00;
      end else if (frz) begin
         sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1; fw = 1'b1;
      end else if (hif.PC_Src_Sel_E) begin
         fd = 1'b1; fe = 1'b1;
      end else if (lu) begin
         sf = 1'b1; sd = 1'b1; fe = 1'b1;
      end
      last_frz = rst && frz;
      chk("stall_f", 32'(hif.Stall_F), 32'(sf));
      chk("stall_d", 32'(hif.Stall_D), 32'(sd));
      chk("stall_e", 32'(hif.Stall_E), 32'(se));
      chk("stall_m", 32'(hif.Stall_M), 32'(sm));
      chk("flush_d", 32'(hif.Flush_D), 32'(fd));
      chk("flush_e", 32'(hif.Flush_E), 32'(fe));
      chk("flush_w", 32'(hif.Flush_W), 32'(fw));
      chk("fwd_a",   32'(hif.Forward_A_Sel_E), 32'(fa));
      chk("fwd_b",   32'(hif.Forward_B_Sel_E), 32'(fb));
      @(posedge clk);
      if (!rst) begin
         m_freeze_len = 0;
         m_fault      = 1'b0;
         m_count      = '0;
      end else begin
         if (sf && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
         if (!m_fault) begin
            if (frz) begin
               m_freeze_len++;
               if (m_freeze_len >= TIMEOUT) m_fault = 1'b1;
            end else begin
               m_freeze_len = 0;
            end
         end
      end
      #1;
      chk("stall_count", hif.Stall_Count, m_count);
      chk("mem_fault",   32'(hif.MEM_Fault), 32'(m_fault));
      @(negedge clk);
   endtask

   initial begin
      int          nfrz;
      logic [31:0] cnt0;
      int          ready_pct;
      checks       = 0;
      failures     = 0;
      m_freeze_len = 0;
      m_fault      = 1'b0;
      m_count      = '0;
      last_frz     = 1'b0;
      set_idle();
      rst = 1'b0;

      // reset
      run_cycle();
      run_cycle();
      chk("reset_count", hif.Stall_Count, 32'd0);
      chk("reset_fault", 32'(hif.MEM_Fault), 32'd0);
      rst = 1'b1;
      run_cycle();

      // load-use
      hif.RD_E = 5'd5; hif.Result_Src_Sel_E = 2'b01; hif.RS2_D = 5'd5;
      run_cycle();
      chk("loaduse_count", hif.Stall_Count, 32'd1);
      hif.RD_E = 5'd0; hif.RS2_D = 5'd0;
      run_cycle();
      chk("loaduse_x0_count", hif.Stall_Count, 32'd1);

      // branch beats load-use
      hif.RD_E = 5'd5; hif.RS2_D = 5'd5; hif.PC_Src_Sel_E = 1'b1;
      run_cycle();
      chk("branch_count", hif.Stall_Count, 32'd1);
      set_idle();

      // forwarding priority
      hif.RS1_E = 5'd7; hif.RD_M = 5'd7; hif.RD_W = 5'd7;
      hif.REG_W_En_M = 1'b1; hif.REG_W_En_W = 1'b1;
      #1 chk("fwd_m_prio", 32'(hif.Forward_A_Sel_E), 32'(FWD_M));
      run_cycle();
      hif.REG_W_En_M = 1'b0;
      #1 chk("fwd_w_only", 32'(hif.Forward_A_Sel_E), 32'(FWD_W));
      run_cycle();
      hif.RS1_E = 5'd0; hif.RD_M = 5'd0; hif.RD_W = 5'd0; hif.REG_W_En_M = 1'b1;
      run_cycle();
      set_idle();

      // memory wait of three cycles
      cnt0 = m_count;
      nfrz = 0;
      hif.MEM_Req_M = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         if (last_frz) nfrz++;
      end
      hif.MEM_Ready = 1'b1;
      run_cycle();
      if (last_frz) nfrz++;
      chk("memwait_frozen_cycles", 32'(nfrz), 32'd3);
      chk("memwait_count_delta", hif.Stall_Count - cnt0, 32'd3);
      hif.MEM_Req_M = 1'b0;
      run_cycle();

      // zero-wait access
      hif.MEM_Req_M = 1'b1; hif.MEM_Ready = 1'b1;
      run_cycle();
      set_idle();

      // timeout into fault
      hif.MEM_Req_M = 1'b1;
      for (int i = 0; i < TIMEOUT - 1; i++) run_cycle();
      chk("fault_not_yet", 32'(hif.MEM_Fault), 32'd0);
      run_cycle();
      chk("fault_set", 32'(hif.MEM_Fault), 32'd1);
      hif.MEM_Ready = 1'b1;
      run_cycle();
      chk("fault_sticky", 32'(hif.MEM_Fault), 32'd1);
      rst = 1'b0;
      run_cycle();
      rst = 1'b1;
      hif.MEM_Req_M = 1'b0;
      run_cycle();
      chk("fault_cleared", 32'(hif.MEM_Fault), 32'd0);

      // reset mid-wait with ready high is ignored
      hif.MEM_Req_M = 1'b1; hif.MEM_Ready = 1'b0;
      run_cycle();
      run_cycle();
      rst = 1'b0; hif.MEM_Ready = 1'b1;
      run_cycle();
      rst = 1'b1; hif.MEM_Req_M = 1'b0; hif.MEM_Ready = 1'b0;
      run_cycle();
      set_idle();

      // random traffic
      ready_pct = 50;
      for (int i = 0; i < 800; i++) begin
         if (i % 60 == 0) ready_pct = $urandom_range(5, 95);
         rst                  = ($urandom_range(0, 99) >= 2);
         hif.RS1_D            = 5'($urandom_range(0, 3));
         hif.RS2_D            = 5'($urandom_range(0, 3));
         hif.RS1_E            = 5'($urandom_range(0, 3));
         hif.RS2_E            = 5'($urandom_range(0, 3));
         hif.RD_E             = 5'($urandom_range(0, 3));
         hif.RD_M             = 5'($urandom_range(0, 3));
         hif.RD_W             = 5'($urandom_range(0, 3));
         hif.Result_Src_Sel_E = 2'($urandom_range(0, 3));
         hif.PC_Src_Sel_E     = ($urandom_range(0, 99) < 20);
         hif.REG_W_En_M       = 1'($urandom_range(0, 1));
         hif.REG_W_En_W       = 1'($urandom_range(0, 1));
         hif.MEM_Req_M        = ($urandom_range(0, 99) < 40);
         hif.MEM_Ready        = ($urandom_range(0, 99) < ready_pct);
         run_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
